shift_sequencer: RTL and testbench

//   Multi-cycle left-shift controller for the ALU's single-bit left shifter.

---
 rtl/shift_sequencer.sv | 84 ++++++++
 tb/tb_shift_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle left-shift sequencer: runs a 1-bit left shift once per clock, Amount times,
// and returns the result with a sticky overflow (OR of every bit shifted out of the MSB).
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] Amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Overflow
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_acc_q;

  logic [WIDTH-1:0] work_shl;
  logic             ovf_next;

  assign work_shl = {work_q[WIDTH-2:0], 1'b0};
  assign ovf_next = ovf_acc_q | work_q[WIDTH-1];

  // Y/Overflow load only on the edge entering StDone, so intermediate shifts stay hidden.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Y         <= '0;
      Overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            work_q    <= A;
            cnt_q     <= Amount;
            ovf_acc_q <= 1'b0;
            busy      <= 1'b1;
            if (Amount != '0) begin
              state_q <= StShift;
            end else begin
              state_q  <= StDone;
              done     <= 1'b1;
              Y        <= A;
              Overflow <= 1'b0;
            end
          end
        end
        StShift: begin
          work_q    <= work_shl;
          ovf_acc_q <= ovf_next;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= StDone;
            done     <= 1'b1;
            Y        <= work_shl;
            Overflow <= ovf_next;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, results, sticky overflow, ignored starts,
// back-to-back operation and mid-operation reset.
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [2:0] Amount;
  logic       busy;
  logic       done;
  logic [7:0] Y;
  logic       Overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] prev_y;
  logic       prev_ovf;

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .Amount   (Amount),
    .busy     (busy),
    .done     (done),
    .Y        (Y),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Starts an op at the current negedge (DUT idle) and checks it through to the idle
  // cycle after done. With hammer set, start stays high with junk during busy cycles.
  task automatic run_op(input string name, input logic [7:0] a, input logic [2:0] amt,
                        input logic [7:0] exp_y, input logic exp_ovf, input bit hammer);
    bit got_done = 0;
    start  = 1'b1;
    A      = a;
    Amount = amt;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start  = hammer;
      A      = 8'hFF;
      Amount = 3'd7 - amt;
      if (done) begin
        check_eq({name, " latency"}, cyc, amt + 1);
        check_eq({name, " Y"}, Y, exp_y);
        check_eq({name, " ovf"}, Overflow, exp_ovf);
        check_eq({name, " busy@done"}, busy, 1);
        got_done = 1;
        break;
      end
      check_eq({name, " busy"}, busy, 1);
      check_eq({name, " Y held"}, Y, prev_y);
      check_eq({name, " ovf held"}, Overflow, prev_ovf);
    end
    check_eq({name, " done seen"}, got_done, 1);
    @(negedge clk);
    start = 1'b0;
    check_eq({name, " idle busy"}, busy, 0);
    check_eq({name, " idle done"}, done, 0);
    check_eq({name, " Y kept"}, Y, exp_y);
    prev_y   = exp_y;
    prev_ovf = exp_ovf;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    A      = 8'h00;
    Amount = 3'd0;
    prev_y   = 8'h00;
    prev_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst Y", Y, 0);
    check_eq("rst ovf", Overflow, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle after rst", busy, 0);

    run_op("81s1", 8'h81, 3'd1, 8'h02, 1'b1, 0);
    run_op("0Fs4", 8'h0F, 3'd4, 8'hF0, 1'b0, 1);
    run_op("A5s0", 8'hA5, 3'd0, 8'hA5, 1'b0, 0);

    // Amount=6 op aborted by reset sampled at the end of cycle 3.
    start  = 1'b1;
    A      = 8'hFF;
    Amount = 3'd6;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("abort busy", busy, 1);
      check_eq("abort no done", done, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort busy0", busy, 0);
    check_eq("abort done0", done, 0);
    check_eq("abort Y0", Y, 0);
    check_eq("abort ovf0", Overflow, 0);
    prev_y   = 8'h00;
    prev_ovf = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      check_eq("abort quiet", {busy, done}, 0);
    end

    run_op("40s7", 8'h40, 3'd7, 8'h00, 1'b1, 0);
    run_op("3Cs2", 8'h3C, 3'd2, 8'hF0, 1'b0, 0);
    run_op("C3s3", 8'hC3, 3'd3, 8'h18, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
